pmp_check_pipe: RTL
===================

Name: pmp_check_pipe

Overview:
- Pipelined, multi-port PMP checker; successor to the combinational single-address PMP unit.
- Adds:
  - NR_PORTS independent request channels with valid/ready handshakes.
  - Access-size range checks, including partial-match detection.
  - A configurable PMP granularity.
  - A shadowed, pre-decoded configuration table that updates safely while requests are in flight.
- Sits between the LSU/fetch address path and the memory interface. Every channel returns a registered allow/deny verdict.

Parameters:
- PLEN, 56, physical address width in bits.
- PMP_LEN, 54, pmpaddr width (PLEN-2).
- NR_ENTRIES, 16, number of PMP entries, 0..64.
- NR_PORTS, 2, number of independent check channels, 1..4.
- PMP_GRAN, 0, granularity G; regions are 2^(G+2) bytes minimum.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- cfg_we_i  in  1  pulse: snapshot conf_addr_i/conf_i.
- conf_addr_i  in  [NR_ENTRIES][PMP_LEN]  pmpaddr values.
- conf_i  in  [NR_ENTRIES] riscv::pmpcfg_t  fields {locked, addr_mode, access_type}.
- cfg_busy_o  out  1  config update in progress.
- req_valid_i  in  [NR_PORTS]  request valid.
- req_ready_o  out  [NR_PORTS]  request ready.
- req_addr_i  in  [NR_PORTS][PLEN]  start byte address.
- req_size_i  in  [NR_PORTS][2]  log2 of the access bytes (0..3).
- req_access_i  in  [NR_PORTS] riscv::pmp_access_t  R=1, W=2, X=4.
- req_priv_i  in  [NR_PORTS] riscv::priv_lvl_t  privilege level.
- rsp_valid_o  out  [NR_PORTS]  response valid.
- rsp_ready_i  in  [NR_PORTS]  response ready.
- rsp_allow_o  out  [NR_PORTS]  1 = access permitted.
- rsp_hit_o  out  [NR_PORTS]  some entry matched, fully or partially.
- rsp_entry_o  out  [NR_PORTS][6]  index of the governing entry; 0 when there is no hit.

Behaviour:
- Reset (rst_i high at a clock edge):
  - All pipeline valids clear; rsp_valid_o=0, rsp_allow_o=0, rsp_hit_o=0, rsp_entry_o=0.
  - Decoded table is cleared to all-OFF; config FSM goes to IDLE; cfg_busy_o=0.
  - Reset mid-operation drops in-flight requests silently.
- Per-port pipeline:
  - S1: request register, loaded on req_valid_i & req_ready_o.
  - S2: output register. Match and priority logic runs between S1 and S2.
  - Latency is 2 cycles from acceptance to rsp_valid_o. Throughput is 1 per cycle per port.
  - Ports are fully independent; responses are returned in order within each port.
  - A response is consumed on rsp_valid_o & rsp_ready_i. rsp_* hold stable while valid and not ready.
  - S1 advances when S2 is empty or being consumed.
  - req_ready_o = (state==IDLE) & (!s1_valid | s1_advance).
- Config FSM:
  - States: IDLE, DRAIN, DECODE.
  - IDLE: cfg_we_i captures conf_addr_i/conf_i into shadow registers, then goes to DRAIN.
  - DRAIN: req_ready_o=0 on all ports; wait until every S1/S2 valid is clear, then go to DECODE.
  - DECODE: one cycle; write the decoded table (TOR bounds, NAPOT base/mask, mode), then return to IDLE.
  - cfg_busy_o=1 in DRAIN and DECODE. cfg_we_i outside IDLE is ignored.
  - In-flight requests always use the table that was live when they were accepted.
- Matching (access range lo=addr, hi=addr+2^size-1, compared in 4-byte word units, addr>>2):
  - OFF: never matches.
  - TOR: prev <= a < cur; prev=0 for entry 0. If prev >= cur, the entry never matches.
  - NA4: a == conf_addr.
  - NAPOT: k trailing ones in conf_addr give a 2^(k+3)-byte region, base = conf_addr with the low k+1 bits cleared.
  - PMP_GRAN>=1: NA4 is treated as OFF. NAPOT low G-1 bits are read as ones. TOR low G bits are read as zeros.
  - Full match: both lo and hi inside the region. Partial match: exactly one of them inside.
- Decision:
  - The lowest-indexed entry with a full or partial match governs: rsp_hit_o=1 and rsp_entry_o=index.
  - Partial match: deny at all privilege levels.
  - Full match, priv!=M or locked: allow iff (req_access & access_type)==req_access.
  - Full match, priv==M and not locked: allow.
  - No match: allow iff priv==M.
  - req_access that is not one-hot: deny.
  - NR_ENTRIES=0: always allow, hit=0; the 2-cycle latency is kept.

Optional Feature:
- PMP_MMWP_EN defined:
  - Adds input mmwp_i (1 bit).
  - When mmwp_i=1, an M-mode request that matches no entry is denied.
- PMP_MMWP_EN undefined:
  - No such port; unmatched M-mode requests are allowed.

Test Plan:
- Reset: hold rst_i 2 cycles -> rsp_valid_o=0, cfg_busy_o=0, and req_ready_o all 1 on the cycle after release.
- TOR case. Setup: entry0 TOR, conf_addr=0x400, R only; U-mode requests.
  - Read 0xFFC, size 2 -> allow=1, hit=1, entry=0, 2 cycles after acceptance.
  - Read 0xFFE, size 2 (partial) -> allow=0.
  - Write 0x100 -> allow=0.
- Priority case. Setup: entry0 NA4 at 0x800010 (conf_addr 0x200004), no permissions; entry1 NAPOT conf_addr=0x2001FF (0x800000-0x800FFF), RWX.
  - S-mode read 0x800010 -> allow=0, entry=0.
  - S-mode read 0x800014 -> allow=1, entry=1.
- M-mode case. Setup: entry0 NA4 at 0x1000, no permissions.
  - Entry locked: M read 0x1000 -> allow=0.
  - Entry unlocked: M read 0x1000 -> allow=1.
  - M read 0x5000 (no match) -> allow=1; with PMP_MMWP_EN and mmwp_i=1 -> allow=0.
- Backpressure: port0 rsp_ready_i=0, 3 back-to-back requests -> 2 accepted, req_ready_o=0 on the third. Release -> 3 responses in order. Port1 continues unaffected throughout.
- Config update mid-flight: cfg_we_i with 2 requests in flight that are allowed by the old config, denied by the new -> both respond allow=1. cfg_busy_o stays high until drain + 1 cycle. The next request responds allow=0.

Source files
------------

// File: rtl/pmp_check_pipe.sv
`default_nettype none
// ============================================================================
// Module   : pmp_check_pipe
// Brief    : Two-stage, multi-port PMP checker with a shadowed, pre-decoded
//            region table. Define PMP_MMWP_EN to add the mmwp_i input.
// Revision : 1.0 - initial release
// ============================================================================
module pmp_check_pipe #(
    parameter int unsigned PLEN       = 56,
    parameter int unsigned PMP_LEN    = 54,
    parameter int unsigned NR_ENTRIES = 16,
    parameter int unsigned NR_PORTS   = 2,
    parameter int unsigned PMP_GRAN   = 0
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_i,
    input  logic                                                 cfg_we_i,
    input  logic [((NR_ENTRIES > 0) ? NR_ENTRIES : 1)-1:0][PMP_LEN-1:0] conf_addr_i,
    input  logic [((NR_ENTRIES > 0) ? NR_ENTRIES : 1)-1:0][7:0]         conf_i,
    output logic                                                 cfg_busy_o,
    input  logic [NR_PORTS-1:0]                                  req_valid_i,
    output logic [NR_PORTS-1:0]                                  req_ready_o,
    input  logic [NR_PORTS-1:0][PLEN-1:0]                        req_addr_i,
    input  logic [NR_PORTS-1:0][1:0]                             req_size_i,
    input  logic [NR_PORTS-1:0][2:0]                             req_access_i,
    input  logic [NR_PORTS-1:0][1:0]                             req_priv_i,
`ifdef PMP_MMWP_EN
    input  logic                                                 mmwp_i,
`endif
    output logic [NR_PORTS-1:0]                                  rsp_valid_o,
    input  logic [NR_PORTS-1:0]                                  rsp_ready_i,
    output logic [NR_PORTS-1:0]                                  rsp_allow_o,
    output logic [NR_PORTS-1:0]                                  rsp_hit_o,
    output logic [NR_PORTS-1:0][5:0]                             rsp_entry_o
);

    localparam int unsigned c_NE = (NR_ENTRIES > 0) ? NR_ENTRIES : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN  = 2'd1;
    localparam logic [1:0] c_ST_DECODE = 2'd2;

    localparam logic [1:0] c_CM_TOR   = 2'd1;
    localparam logic [1:0] c_CM_NA4   = 2'd2;
    localparam logic [1:0] c_CM_NAPOT = 2'd3;

    // Decoded modes: MASK covers both NA4 and NAPOT as (word & mask) == base
    localparam logic [1:0] c_DM_OFF  = 2'd0;
    localparam logic [1:0] c_DM_TOR  = 2'd1;
    localparam logic [1:0] c_DM_MASK = 2'd2;

    localparam logic [PMP_LEN-1:0] c_ONE       = {{(PMP_LEN-1){1'b0}}, 1'b1};
    localparam logic [PMP_LEN-1:0] c_TOR_MASK  = ~((c_ONE << PMP_GRAN) - c_ONE);
    localparam logic [PMP_LEN-1:0] c_NAPOT_ONES =
        (PMP_GRAN >= 1) ? ((c_ONE << ((PMP_GRAN >= 1) ? PMP_GRAN - 1 : 0)) - c_ONE)
                        : {PMP_LEN{1'b0}};

    logic [1:0]                      r_state;
    logic [NR_PORTS-1:0]             w_s1_vld;
    logic [NR_PORTS-1:0]             w_s2_vld;
    logic                            w_pipe_empty;
    logic                            w_mmwp;

    logic [c_NE-1:0][PMP_LEN-1:0]    r_sh_addr;
    logic [c_NE-1:0]                 r_sh_lock;
    logic [c_NE-1:0][1:0]            r_sh_mode;
    logic [c_NE-1:0][2:0]            r_sh_acc;

    logic [c_NE-1:0][1:0]            w_dec_mode;
    logic [c_NE-1:0][PMP_LEN-1:0]    w_dec_a;
    logic [c_NE-1:0][PMP_LEN-1:0]    w_dec_b;

    logic [c_NE-1:0][1:0]            r_tab_mode;
    logic [c_NE-1:0][PMP_LEN-1:0]    r_tab_a;
    logic [c_NE-1:0][PMP_LEN-1:0]    r_tab_b;
    logic [c_NE-1:0][2:0]            r_tab_acc;
    logic [c_NE-1:0]                 r_tab_lock;

    logic                            w_unused_cfg;

`ifdef PMP_MMWP_EN
    assign w_mmwp = mmwp_i;
`else
    assign w_mmwp = 1'b0;
`endif

    assign w_pipe_empty = ~|{w_s1_vld, w_s2_vld};
    assign cfg_busy_o   = (r_state != c_ST_IDLE);

    always_comb begin
        w_unused_cfg = 1'b0;
        for (int i = 0; i < c_NE; i++) begin
            w_unused_cfg = w_unused_cfg ^ (^conf_i[i][6:5]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:   if (cfg_we_i) r_state <= c_ST_DRAIN;
                c_ST_DRAIN:  if (w_pipe_empty) r_state <= c_ST_DECODE;
                c_ST_DECODE: r_state <= c_ST_IDLE;
                default:     r_state <= c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sh_addr <= '0;
            r_sh_lock <= '0;
            r_sh_mode <= '0;
            r_sh_acc  <= '0;
        end else if (r_state == c_ST_IDLE && cfg_we_i) begin
            r_sh_addr <= conf_addr_i;
            for (int i = 0; i < c_NE; i++) begin
                r_sh_lock[i] <= conf_i[i][7];
                r_sh_mode[i] <= conf_i[i][4:3];
                r_sh_acc[i]  <= conf_i[i][2:0];
            end
        end
    end

    for (genvar i = 0; i < c_NE; i++) begin : g_dec
        logic [PMP_LEN-1:0] w_prev;
        logic [PMP_LEN-1:0] w_cur;
        logic [PMP_LEN-1:0] w_napot;
        logic [PMP_LEN-1:0] w_nmask;
        logic [1:0]         w_mode;
        logic [PMP_LEN-1:0] w_a;
        logic [PMP_LEN-1:0] w_b;

        if (i == 0) begin : g_first
            assign w_prev = '0;
        end else begin : g_rest
            assign w_prev = r_sh_addr[i-1] & c_TOR_MASK;
        end

        assign w_cur   = r_sh_addr[i] & c_TOR_MASK;
        assign w_napot = r_sh_addr[i] | c_NAPOT_ONES;
        // a ^ (a+1) sets exactly the trailing ones plus the first zero
        assign w_nmask = ~(w_napot ^ (w_napot + c_ONE));

        always_comb begin
            w_mode = c_DM_OFF;
            w_a    = '0;
            w_b    = '0;
            case (r_sh_mode[i])
                c_CM_TOR: begin
                    if (w_prev < w_cur) begin
                        w_mode = c_DM_TOR;
                        w_a    = w_prev;
                        w_b    = w_cur;
                    end
                end
                c_CM_NA4: begin
                    if (PMP_GRAN == 0) begin
                        w_mode = c_DM_MASK;
                        w_a    = r_sh_addr[i];
                        w_b    = '1;
                    end
                end
                c_CM_NAPOT: begin
                    w_mode = c_DM_MASK;
                    w_a    = w_napot & w_nmask;
                    w_b    = w_nmask;
                end
                default: ;
            endcase
        end

        assign w_dec_mode[i] = w_mode;
        assign w_dec_a[i]    = w_a;
        assign w_dec_b[i]    = w_b;
    end

    // The table only changes while the pipeline is empty, so in-flight
    // requests always complete against the table they were accepted under.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tab_mode <= '0;
            r_tab_a    <= '0;
            r_tab_b    <= '0;
            r_tab_acc  <= '0;
            r_tab_lock <= '0;
        end else if (r_state == c_ST_DECODE) begin
            r_tab_mode <= w_dec_mode;
            r_tab_a    <= w_dec_a;
            r_tab_b    <= w_dec_b;
            r_tab_acc  <= r_sh_acc;
            r_tab_lock <= r_sh_lock;
        end
    end

    for (genvar p = 0; p < NR_PORTS; p++) begin : g_port
        logic               r_s1_valid;
        logic [PLEN-1:0]    r_addr;
        logic [1:0]         r_size;
        logic [2:0]         r_acc;
        logic [1:0]         r_priv;
        logic               r_s2_valid;
        logic               r_allow;
        logic               r_hit;
        logic [5:0]         r_entry;

        logic               w_s2_free;
        logic               w_fire;
        logic [3:0]         w_span;
        logic [PLEN-1:0]    w_hi_byte;
        logic [PMP_LEN-1:0] w_lo;
        logic [PMP_LEN-1:0] w_hi;
        logic               w_hit;
        logic               w_full;
        logic [5:0]         w_idx;
        logic [2:0]         w_sel_acc;
        logic               w_sel_lock;
        logic               w_is_m;
        logic               w_onehot;
        logic               w_allow;

        assign w_s2_free      = ~r_s2_valid | rsp_ready_i[p];
        assign req_ready_o[p] = (r_state == c_ST_IDLE) & (~r_s1_valid | w_s2_free);
        assign w_fire         = req_valid_i[p] & req_ready_o[p];

        assign w_span    = (4'd1 << r_size) - 4'd1;
        assign w_hi_byte = r_addr + {{(PLEN-4){1'b0}}, w_span};
        assign w_lo      = r_addr[PLEN-1:2];
        assign w_hi      = w_hi_byte[PLEN-1:2];

        // Walk from the highest entry down so the lowest matching index wins
        always_comb begin
            logic w_lo_in;
            logic w_hi_in;
            w_hit      = 1'b0;
            w_full     = 1'b0;
            w_idx      = '0;
            w_sel_acc  = '0;
            w_sel_lock = 1'b0;
            for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
                w_lo_in = 1'b0;
                w_hi_in = 1'b0;
                case (r_tab_mode[i])
                    c_DM_TOR: begin
                        w_lo_in = (w_lo >= r_tab_a[i]) && (w_lo < r_tab_b[i]);
                        w_hi_in = (w_hi >= r_tab_a[i]) && (w_hi < r_tab_b[i]);
                    end
                    c_DM_MASK: begin
                        w_lo_in = ((w_lo & r_tab_b[i]) == r_tab_a[i]);
                        w_hi_in = ((w_hi & r_tab_b[i]) == r_tab_a[i]);
                    end
                    default: ;
                endcase
                if (w_lo_in || w_hi_in) begin
                    w_hit      = 1'b1;
                    w_full     = w_lo_in & w_hi_in;
                    w_idx      = 6'(i);
                    w_sel_acc  = r_tab_acc[i];
                    w_sel_lock = r_tab_lock[i];
                end
            end
        end

        always_comb begin
            w_is_m   = (r_priv == 2'b11);
            w_onehot = (r_acc == 3'b001) || (r_acc == 3'b010) || (r_acc == 3'b100);
            if (NR_ENTRIES == 0)             w_allow = 1'b1;
            else if (!w_onehot)              w_allow = 1'b0;
            else if (!w_hit)                 w_allow = w_is_m & ~w_mmwp;
            else if (!w_full)                w_allow = 1'b0;
            else if (w_is_m && !w_sel_lock)  w_allow = 1'b1;
            else                             w_allow = ((r_acc & w_sel_acc) == r_acc);
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_s1_valid <= 1'b0;
                r_addr     <= '0;
                r_size     <= '0;
                r_acc      <= '0;
                r_priv     <= '0;
                r_s2_valid <= 1'b0;
                r_allow    <= 1'b0;
                r_hit      <= 1'b0;
                r_entry    <= '0;
            end else begin
                if (w_fire) begin
                    r_s1_valid <= 1'b1;
                    r_addr     <= req_addr_i[p];
                    r_size     <= req_size_i[p];
                    r_acc      <= req_access_i[p];
                    r_priv     <= req_priv_i[p];
                end else if (w_s2_free) begin
                    r_s1_valid <= 1'b0;
                end
                if (w_s2_free) begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_allow <= w_allow;
                        r_hit   <= w_hit;
                        r_entry <= w_idx;
                    end
                end
            end
        end

        assign w_s1_vld[p]    = r_s1_valid;
        assign w_s2_vld[p]    = r_s2_valid;
        assign rsp_valid_o[p] = r_s2_valid;
        assign rsp_allow_o[p] = r_allow;
        assign rsp_hit_o[p]   = r_hit;
        assign rsp_entry_o[p] = r_entry;
    end

endmodule
`default_nettype wire
